// File: rtl/uart_frame_sender.sv
// Frames FIFO payload bytes as HEADER, LEN, payload, optional XOR checksum and
// hands them one at a time to a uart_transmit block via a send/ready handshake.
module uart_frame_sender #(
  parameter int                 DATA_W      = 8,
  parameter int                 DEPTH       = 16,
  parameter logic [DATA_W-1:0]  HEADER      = 8'hA5,
  parameter bit                 CHECKSUM_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      send,
  input  logic                      send_ready,
  output logic                      start_transmit,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_READY, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   len, chk;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       pay_end, total;
  logic                push, pop;

  // idx walks the frame: 0 header, 1 length, 2..pay_end-1 payload, then checksum
  assign pay_end = IW'(len) + IW'(2);
  assign total   = pay_end + IW'(CHECKSUM_EN);
  assign full    = (count == DEPTH[AW:0]);
  assign push    = wr_en && !full;
  assign pop     = (state == LOAD) && (idx >= IW'(2)) && (idx < pay_end);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tx_data        <= '0;
      start_transmit <= 1'b0;
      frame_done     <= 1'b0;
      len            <= '0;
      chk            <= '0;
      idx            <= '0;
    end else begin
      start_transmit <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE: if (send && count != '0) begin
          len   <= DATA_W'(count);
          chk   <= DATA_W'(count);
          idx   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (idx == IW'(0))      tx_data <= HEADER;
          else if (idx == IW'(1)) tx_data <= len;
          else if (pop) begin
            tx_data <= mem[rd_ptr];
            chk     <= chk ^ mem[rd_ptr];
          end else                tx_data <= chk;
          idx   <= idx + 1'b1;
          state <= START;
        end
        START: if (send_ready) begin
          start_transmit <= 1'b1;
          state          <= WAIT_BUSY;
        end
        WAIT_BUSY:  if (!send_ready) state <= WAIT_READY;
        WAIT_READY: if (send_ready) state <= (idx < total) ? LOAD : DONE;
        DONE: begin
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_sender.sv
// Scoreboard bench: three instances (default, no checksum, depth 4) share one
// transmitter model; expected frame bytes are queued when send is accepted.
module tb_uart_frame_sender;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       wr_en [3];
  logic [7:0] wr_data [3];
  logic       send [3];
  logic       rdy_m [3];
  logic       send_ready [3];
  logic       force_low;
  logic       start_tx [3];
  logic [7:0] tx_data [3];
  logic       full [3];
  logic       busy [3];
  logic       fdone [3];
  logic [4:0] cnt0, cnt1;
  logic [2:0] cnt2;

  assign send_ready[0] = rdy_m[0] & ~force_low;
  assign send_ready[1] = rdy_m[1] & ~force_low;
  assign send_ready[2] = rdy_m[2] & ~force_low;

  uart_frame_sender dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .send(send[0]),
    .send_ready(send_ready[0]), .start_transmit(start_tx[0]), .tx_data(tx_data[0]),
    .full(full[0]), .count(cnt0), .busy(busy[0]), .frame_done(fdone[0]));
  uart_frame_sender #(.CHECKSUM_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .send(send[1]),
    .send_ready(send_ready[1]), .start_transmit(start_tx[1]), .tx_data(tx_data[1]),
    .full(full[1]), .count(cnt1), .busy(busy[1]), .frame_done(fdone[1]));
  uart_frame_sender #(.DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .send(send[2]),
    .send_ready(send_ready[2]), .start_transmit(start_tx[2]), .tx_data(tx_data[2]),
    .full(full[2]), .count(cnt2), .busy(busy[2]), .frame_done(fdone[2]));

  int checks = 0, errors = 0;
  int strobes [3], dones [3], tmr [3];
  int act;
  bit mbusy;
  logic [7:0] exp_q [$];
  logic [7:0] mq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int depth_of(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic logic [31:0] count_of(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  // Transmitter model plus output monitor; ready drops for 10 cycles per strobe.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rdy_m[i] = 1'b1;
        tmr[i]   = 0;
      end else begin
        if (start_tx[i]) begin
          strobes[i]++;
          rdy_m[i] = 1'b0;
          tmr[i]   = 10;
          if (i == act) begin
            check("exp_byte_avail", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_byte", 32'(tx_data[i]), 32'(exp_q.pop_front()));
          end
        end else if (tmr[i] > 0) begin
          tmr[i]--;
          if (tmr[i] == 0) rdy_m[i] = 1'b1;
        end
        if (fdone[i]) begin
          dones[i]++;
          if (i == act) mbusy = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    wr_en[act] = 1'b1;
    wr_data[act] = b;
    if (mq.size() < depth_of(act)) mq.push_back(b);
    @(negedge clk);
    wr_en[act] = 1'b0;
  endtask

  task automatic send_frame();
    logic [7:0] c, b, n;
    send[act] = 1'b1;
    if (!mbusy && mq.size() > 0) begin
      n = 8'(mq.size());
      exp_q.push_back(8'hA5);
      exp_q.push_back(n);
      c = n;
      for (int k = 0; k < int'(n); k++) begin
        b = mq.pop_front();
        exp_q.push_back(b);
        c = c ^ b;
      end
      if (act != 1) exp_q.push_back(c);
      mbusy = 1'b1;
    end
    @(negedge clk);
    send[act] = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (dones[act] == n0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", 32'(dones[act] != n0), 1);
    repeat (3) @(negedge clk);
    check("frame_done_once", 32'(dones[act]), 32'(n0 + 1));
    check("exp_q_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n, t;
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = 0; wr_data[i] = 0; send[i] = 0; rdy_m[i] = 1;
      strobes[i] = 0; dones[i] = 0; tmr[i] = 0;
    end
    force_low = 0; act = 0; mbusy = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(start_tx[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_fdone", 32'(fdone[0]), 0);
    check("rst_full", 32'(full[0]), 0);
    check("rst_txdata", 32'(tx_data[0]), 0);
    check("rst_count", count_of(0), 0);
    rst = 0;
    @(negedge clk);

    // basic 3-byte frame with checksum
    push(8'h01); push(8'h02); push(8'h03);
    check("count_3", count_of(0), 3);
    send_frame();
    wait_done(0);
    check("count_after", count_of(0), 0);
    check("strobes_6", 32'(strobes[0]), 6);

    // no checksum
    act = 1;
    push(8'hFF);
    send_frame();
    wait_done(0);
    check("strobes_nochk", 32'(strobes[1]), 3);

    // depth 4: fill, drop overflow
    act = 2;
    push(8'h10); push(8'h11); push(8'h12);
    check("not_full_3", 32'(full[2]), 0);
    push(8'h13);
    check("full_4", 32'(full[2]), 1);
    push(8'h14);
    check("count_4", count_of(2), 4);
    check("full_still", 32'(full[2]), 1);
    send_frame();
    wait_done(0);
    check("count_d4_empty", count_of(2), 0);

    // push and re-send during a frame
    act = 0;
    push(8'hAA); push(8'hBB);
    send_frame();
    repeat (3) @(negedge clk);
    push(8'h55);
    send_frame();
    wait_done(1);
    check("count_held", count_of(0), 1);
    send_frame();
    wait_done(2);
    check("count_held_empty", count_of(0), 0);

    // ready held low: stall in START, strobe one cycle after release
    force_low = 1;
    push(8'h07);
    n = strobes[0];
    send_frame();
    repeat (10) @(negedge clk);
    check("stall_busy", 32'(busy[0]), 1);
    check("stall_no_strobe", 32'(strobes[0]), 32'(n));
    force_low = 0;
    @(negedge clk);
    check("strobe_after_release", 32'(start_tx[0]), 1);
    wait_done(3);

    // reset mid-frame
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    n = strobes[0];
    send_frame();
    t = 0;
    while (strobes[0] < n + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("second_byte_seen", 32'(strobes[0]), 32'(n + 2));
    rst = 1; wr_en[0] = 1; wr_data[0] = 8'h99; send[0] = 1;
    exp_q.delete(); mq.delete(); mbusy = 0;
    @(negedge clk);
    check("mid_rst_start", 32'(start_tx[0]), 0);
    check("mid_rst_busy", 32'(busy[0]), 0);
    check("mid_rst_txdata", 32'(tx_data[0]), 0);
    check("mid_rst_count", count_of(0), 0);
    @(negedge clk);
    rst = 0; wr_en[0] = 0; send[0] = 0;
    repeat (40) @(negedge clk);
    check("no_strobe_after_rst", 32'(strobes[0]), 32'(n + 2));
    check("count_after_rst", count_of(0), 0);
    check("idle_after_rst", 32'(busy[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
